// File: rtl/updown_counter_cfg.sv
// updown_counter_cfg
//   Parametrised up/down counter over the range [0..MAX_VAL] with a parallel
//   load and a choice of terminal behaviour (wrap, saturate, auto-reload).
//   A step taken at a range boundary raises tc for one cycle. The pulse is
//   registered, so it lines up with the new count value.
//
// Parameters
//   WIDTH      count width in bits (>=2)
//   MAX_VAL    inclusive upper bound of the count range
//   RESET_VAL  value of count and of the reload register after reset
//   MODE       0 = wrap, 1 = saturate, 2 = auto-reload
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous reset, active-high
//   enable    in   advance the count one step this cycle
//   up_dn     in   1 = count up, 0 = count down (used only with enable)
//   load      in   load load_val into count and reload register
//   load_val  in   parallel load value, clamped to MAX_VAL
//   count     out  current count (registered)
//   tc        out  terminal-count pulse (registered, one cycle)
//   at_max    out  count == MAX_VAL (combinational)
//   at_min    out  count == 0 (combinational)
//
// Priority per cycle: reset > load > enable > hold.

module updown_counter_cfg #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = MAX_VAL,
  parameter int MODE      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  generate
    if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > (2**WIDTH)-1 ||
        RESET_VAL < 0 || RESET_VAL > MAX_VAL || MODE < 0 || MODE > 2) begin : g_bad_params
      $error("updown_counter_cfg: illegal parameter combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_reload_next;
  logic             w_tc_next;
  logic             w_boundary;

  // When MAX_VAL fills the whole WIDTH-bit range no load value can exceed
  // it, so the clamp comparator is only built for a partial range.
  generate
    if (MAX_VAL == (2**WIDTH)-1) begin : g_full_range
      assign w_load_clamped = load_val;
    end else begin : g_clamp
      assign w_load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
    end
  endgenerate

  // A boundary is judged on the current count and the current direction,
  // so count==0 counting up is an ordinary step.
  assign w_boundary = up_dn ? (r_count == MAX_C) : (r_count == '0);

  always_comb begin
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_tc_next     = 1'b0;
    if (load) begin
      // A load wins over a simultaneous enable; no step is taken.
      w_count_next  = w_load_clamped;
      w_reload_next = w_load_clamped;
    end else if (enable) begin
      if (w_boundary) begin
        w_tc_next = 1'b1;
        if (MODE == 0) begin
          w_count_next = up_dn ? '0 : MAX_C;
        end else if (MODE == 1) begin
          w_count_next = r_count;
        end else begin
          w_count_next = r_reload;
        end
      end else begin
        w_count_next = up_dn ? (r_count + ONE_C) : (r_count - ONE_C);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= RESET_C;
      r_reload <= RESET_C;
      r_tc     <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_tc     <= w_tc_next;
    end
  end

  assign count  = r_count;
  assign tc     = r_tc;
  assign at_max = (r_count == MAX_C);
  assign at_min = (r_count == '0);

endmodule
